// File: rtl/arbitro_somador_pkg.sv
// arbitro_somador_pkg: shared operand width and FSM state encoding for the adder arbiter
package arbitro_somador_pkg;
  localparam int WIDTH = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/bin2bcd_5.sv
// bin2bcd_5: combinational 5-bit binary (0..30) to BCD; bin_i in, dezena_o/unidade_o out
module bin2bcd_5 (
  input  logic [4:0] bin_i,
  output logic [3:0] dezena_o,
  output logic [3:0] unidade_o
);
  logic [4:0] tens;
  assign dezena_o  = bin_i >= 5'd30 ? 4'd3 : bin_i >= 5'd20 ? 4'd2 : bin_i >= 5'd10 ? 4'd1 : 4'd0;
  assign tens      = bin_i >= 5'd30 ? 5'd30 : bin_i >= 5'd20 ? 5'd20 : bin_i >= 5'd10 ? 5'd10 : 5'd0;
  assign unidade_o = 4'(bin_i - tens);
endmodule

// File: rtl/somador_4_bits.sv
// somador_4_bits: 4-bit ripple-carry adder; ports a_i/b_i/cin_i in, soma_o/cout_o out
module somador_4_bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] soma_o,
  output logic       cout_o
);
  logic [4:0] c;
  assign c[0] = cin_i;
  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign soma_o[g] = a_i[g] ^ b_i[g] ^ c[g];
    assign c[g+1]    = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
  end
  assign cout_o = c[4];
endmodule

// File: rtl/arbitro_somador.sv
// arbitro_somador: round-robin arbiter sharing one 4-bit adder among NREQ requesters.
// Ports: clk_i, rst_ni (sync, active-low); req_i, op_a_i, op_b_i (requester i owns
// bits [i*WIDTH +: WIDTH]); grant_o, ack_o, busy_o; result_o, result_id_o, dezena_o, unidade_o.
module arbitro_somador
  import arbitro_somador_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] op_a_i,
  input  logic [NREQ*WIDTH-1:0] op_b_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [NREQ-1:0]       ack_o,
  output logic                  busy_o,
  output logic [WIDTH:0]        result_o,
  output logic [IDW-1:0]        result_id_o,
  output logic [3:0]            dezena_o,
  output logic [3:0]            unidade_o
);
  localparam logic [IDW:0] N = (IDW+1)'(NREQ);
  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d, win_q, win_d, pick, id_q, id_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, soma;
  logic [WIDTH:0]   res_q, res_d;
  logic [3:0]       dez_q, dez_d, uni_q, uni_d, dez, uni;
  logic [IDW:0]     s;
  logic             any, cout;
  somador_4_bits u_soma (.a_i(opa_q), .b_i(opb_q), .cin_i(1'b0), .soma_o(soma), .cout_o(cout));
  bin2bcd_5 u_bcd (.bin_i({cout, soma}), .dezena_o(dez), .unidade_o(uni));
  // Scan from the farthest offset down so the lowest offset from ptr is the last (winning) hit.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    s    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr_q} + (IDW+1)'(k);
      s = s >= N ? s - N : s;
      if (req_i[IDW'(s)]) begin
        pick = IDW'(s);
        any  = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    id_d    = id_q;
    dez_d   = dez_q;
    uni_d   = uni_q;
    case (state_q)
      ST_IDLE: begin
        state_d = any ? ST_LOAD : ST_IDLE;
        win_d   = any ? pick : win_q;
      end
      ST_LOAD: begin
        state_d = ST_CALC;
        for (int i = 0; i < NREQ; i++) begin
          if (win_q == IDW'(i)) begin
            opa_d = op_a_i[i*WIDTH +: WIDTH];
            opb_d = op_b_i[i*WIDTH +: WIDTH];
          end
        end
      end
      ST_CALC: begin
        state_d = ST_DONE;
        res_d   = {cout, soma};
        id_d    = win_q;
        dez_d   = dez;
        uni_d   = uni;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = win_q == IDW'(NREQ - 1) ? '0 : win_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      id_q    <= '0;
      dez_q   <= '0;
      uni_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      id_q    <= id_d;
      dez_q   <= dez_d;
      uni_q   <= uni_d;
    end
  end
  assign busy_o      = state_q != ST_IDLE;
  assign grant_o     = busy_o ? NREQ'(1) << win_q : '0;
  assign ack_o       = state_q == ST_DONE ? grant_o : '0;
  assign result_o    = res_q;
  assign result_id_o = id_q;
  assign dezena_o    = dez_q;
  assign unidade_o   = uni_q;
endmodule

// File: tb/tb_arbitro_somador.sv
// tb_arbitro_somador: directed self-checking bench for arbitro_somador
module tb_arbitro_somador;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, grant, ack;
  logic [7:0] op_a, op_b;
  logic       busy;
  logic [4:0] result;
  logic [0:0] result_id;
  logic [3:0] dezena, unidade;
  int errs = 0;
  int checks = 0;
  arbitro_somador #(.NREQ(2), .IDW(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_a_i(op_a), .op_b_i(op_b),
    .grant_o(grant), .ack_o(ack), .busy_o(busy), .result_o(result),
    .result_id_o(result_id), .dezena_o(dezena), .unidade_o(unidade)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    req   = 2'b11;
    op_a  = 8'h00;
    op_b  = 8'h00;
    tick(2);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_id", 32'(result_id), 0);
    chk("rst_dezena", 32'(dezena), 0);
    chk("rst_unidade", 32'(unidade), 0);
    rst_n = 1'b1;
    req   = 2'b01;
    op_a  = {4'd0, 4'd9};
    op_b  = {4'd0, 4'd8};
    tick();
    chk("single_load_grant", 32'(grant), 1);
    chk("single_load_busy", 32'(busy), 1);
    chk("single_load_ack", 32'(ack), 0);
    tick();
    chk("single_calc_ack", 32'(ack), 0);
    tick();
    chk("single_done_ack", 32'(ack), 1);
    chk("single_result", 32'(result), 17);
    chk("single_dezena", 32'(dezena), 1);
    chk("single_unidade", 32'(unidade), 7);
    chk("single_id", 32'(result_id), 0);
    req = 2'b00;
    tick();
    chk("single_idle_busy", 32'(busy), 0);
    chk("single_idle_ack", 32'(ack), 0);
    chk("single_hold_result", 32'(result), 17);
    rst_n = 1'b0;
    tick();
    chk("rst2_result", 32'(result), 0);
    rst_n = 1'b1;
    req   = 2'b11;
    op_a  = {4'd3, 4'd15};
    op_b  = {4'd4, 4'd15};
    tick();
    chk("cont1_grant", 32'(grant), 1);
    tick(2);
    chk("cont1_ack", 32'(ack), 1);
    chk("cont1_result", 32'(result), 30);
    chk("cont1_dezena", 32'(dezena), 3);
    chk("cont1_unidade", 32'(unidade), 0);
    tick();
    chk("cont1_idle_grant", 32'(grant), 0);
    tick();
    chk("cont2_grant", 32'(grant), 2);
    tick(2);
    chk("cont2_ack", 32'(ack), 2);
    chk("cont2_result", 32'(result), 7);
    chk("cont2_id", 32'(result_id), 1);
    chk("cont2_unidade", 32'(unidade), 7);
    tick(2);
    chk("cont3_grant", 32'(grant), 1);
    tick(2);
    chk("cont3_ack", 32'(ack), 1);
    chk("cont3_result", 32'(result), 30);
    req = 2'b10;
    tick(2);
    chk("cont4_grant", 32'(grant), 2);
    tick(2);
    chk("cont4_ack", 32'(ack), 2);
    req = 2'b00;
    tick();
    req  = 2'b01;
    op_a = {4'd3, 4'd5};
    op_b = {4'd4, 4'd1};
    tick(2);
    op_a = {4'd3, 4'd12};
    tick();
    chk("stab_ack", 32'(ack), 1);
    chk("stab_result", 32'(result), 6);
    req = 2'b00;
    tick();
    req  = 2'b10;
    op_a = {4'd7, 4'd12};
    op_b = {4'd2, 4'd1};
    tick();
    chk("abort_load_grant", 32'(grant), 2);
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_grant", 32'(grant), 0);
    chk("abort_result", 32'(result), 0);
    rst_n = 1'b1;
    req   = 2'b11;
    tick();
    chk("abort_ptr0_grant", 32'(grant), 1);
    tick(2);
    chk("abort_req0_ack", 32'(ack), 1);
    chk("abort_req0_result", 32'(result), 13);
    req = 2'b10;
    tick(2);
    chk("abort_req1_grant", 32'(grant), 2);
    tick();
    chk("abort_req1_calc_ack", 32'(ack), 0);
    tick();
    chk("abort_req1_ack", 32'(ack), 2);
    chk("abort_req1_result", 32'(result), 9);
    chk("abort_req1_id", 32'(result_id), 1);
    req = 2'b00;
    tick();
    req  = 2'b01;
    op_a = {4'd0, 4'd4};
    op_b = {4'd0, 4'd4};
    tick();
    req = 2'b00;
    tick(2);
    chk("drop_ack", 32'(ack), 1);
    chk("drop_result", 32'(result), 8);
    chk("drop_unidade", 32'(unidade), 8);
    tick();
    chk("drop_idle_busy", 32'(busy), 0);
    tick();
    chk("drop_stay_busy", 32'(busy), 0);
    chk("drop_stay_grant", 32'(grant), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
